// File: rtl/nn_cls_pkg.sv
`default_nettype none
// ============================================================================
// nn_cls_pkg : shared geometry constants and FSM encoding for the
//              classification frame loader.
// Rev 1.0
// ============================================================================
package nn_cls_pkg;

  localparam int DATA_W        = 16;   // Q6.10 word
  localparam int BRAM_W        = 64;
  localparam int ADDR_W        = 4;
  localparam int N_ROWS        = 9;
  localparam int N_WB          = 10;   // weight rows plus the bias row
  localparam int N_OUT         = 4;
  localparam int WORDS_PER_ROW = 4;
  localparam int WE_W          = BRAM_W / 8;

  typedef enum logic [2:0] {
    LOAD      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    RD_REQ    = 3'd3,
    RD_CAP    = 3'd4,
    RD_OUT    = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/nn_cls_row_packer.sv
`default_nettype none
// ============================================================================
// nn_cls_row_packer : formats three x words and one weight word into the
//                     64-bit rows stored in the x and weight/bias BRAMs.
// Rev 1.0
// ============================================================================
module nn_cls_row_packer
  import nn_cls_pkg::*;
#(
  parameter int WORD_W = DATA_W,
  parameter int ROW_W  = BRAM_W
) (
  input  logic [WORD_W-1:0] x1,
  input  logic [WORD_W-1:0] x2,
  input  logic [WORD_W-1:0] x3,
  input  logic [WORD_W-1:0] w,
  output logic [ROW_W-1:0]  xij_row,
  output logic [ROW_W-1:0]  wb_row
);

  localparam int c_X_PAD = ROW_W - 3 * WORD_W;
  localparam int c_W_PAD = ROW_W - WORD_W;

  // Words are left-justified; the unused low lanes read back as zero.
  assign xij_row = {x1, x2, x3, {c_X_PAD{1'b0}}};
  assign wb_row  = {w, {c_W_PAD{1'b0}}};

endmodule
`default_nettype wire

// File: rtl/nn_classification_loader.sv
`default_nettype none
// ============================================================================
// nn_classification_loader : streams one frame of x/weight/bias words into the
//   classifier BRAMs, kicks the classifier and streams its results back out.
// Rev 1.0
// ============================================================================
module nn_classification_loader #(
  parameter int DATA_W = nn_cls_pkg::DATA_W,
  parameter int N_ROWS = nn_cls_pkg::N_ROWS,
  parameter int N_OUT  = nn_cls_pkg::N_OUT
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              clr,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [DATA_W-1:0]                 s_data,
  output logic                              xij_ena,
  output logic [nn_cls_pkg::WE_W-1:0]       xij_wea,
  output logic [nn_cls_pkg::ADDR_W-1:0]     xij_addra,
  output logic [nn_cls_pkg::BRAM_W-1:0]     xij_dina,
  output logic                              wb_ena,
  output logic [nn_cls_pkg::WE_W-1:0]       wb_wea,
  output logic [nn_cls_pkg::ADDR_W-1:0]     wb_addra,
  output logic [nn_cls_pkg::BRAM_W-1:0]     wb_dina,
  input  logic                              nn_ready,
  output logic                              nn_start,
  input  logic                              nn_done,
  output logic                              xout_enb,
  output logic [nn_cls_pkg::ADDR_W-1:0]     xout_addrb,
  input  logic [DATA_W-1:0]                 xout_doutb,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [DATA_W-1:0]                 m_data,
  output logic                              m_last,
  output logic                              alert,
  output logic                              busy
);

  import nn_cls_pkg::*;

  localparam int                c_K_W      = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [ADDR_W-1:0] c_BIAS_ROW = ADDR_W'(N_ROWS);
  localparam logic [c_K_W-1:0]  c_K_LAST   = c_K_W'(N_OUT - 1);
  localparam logic [1:0]        c_W_LAST   = 2'd3;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_row;
  logic [1:0]          r_word;
  logic [c_K_W-1:0]    r_k;
  logic [DATA_W-1:0]   r_x1;
  logic [DATA_W-1:0]   r_x2;
  logic [DATA_W-1:0]   r_x3;
  logic [DATA_W-1:0]   r_m_data;
  logic                r_m_last;
  logic                r_alert;

  logic                w_active;
  logic                w_accept;
  logic                w_row_wr;
  logic                w_bias_wr;
  logic                w_beat;
  logic                w_in_bias;
  logic                w_k_last;
  logic [BRAM_W-1:0]   w_xij_row;
  logic [BRAM_W-1:0]   w_wb_row;

  assign w_active  = rst_n & en & ~clr;
  assign w_in_bias = (r_row == c_BIAS_ROW);
  assign w_k_last  = (r_k == c_K_LAST);

  nn_cls_row_packer #(
    .WORD_W (DATA_W),
    .ROW_W  (BRAM_W)
  ) u_row_packer (
    .x1      (r_x1),
    .x2      (r_x2),
    .x3      (r_x3),
    .w       (s_data),
    .xij_row (w_xij_row),
    .wb_row  (w_wb_row)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Every strobe is qualified by w_active, so a frozen or resetting block is silent.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_row_wr    = 1'b0;
    w_bias_wr   = 1'b0;
    w_beat      = 1'b0;
    s_ready     = 1'b0;
    nn_start    = 1'b0;
    xout_enb    = 1'b0;
    m_valid     = 1'b0;
    if (w_active) begin
      case (r_state)
        LOAD: begin
          s_ready = 1'b1;
          if (s_valid) begin
            w_accept = 1'b1;
            if (w_in_bias) begin
              w_bias_wr   = 1'b1;
              w_state_nxt = START;
            end else if (r_word == c_W_LAST) begin
              w_row_wr = 1'b1;
            end
          end
        end
        START: begin
          nn_start = nn_ready;
          if (nn_ready) begin
            w_state_nxt = WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (nn_done) begin
            w_state_nxt = RD_REQ;
          end
        end
        RD_REQ: begin
          xout_enb    = 1'b1;
          w_state_nxt = RD_CAP;
        end
        RD_CAP: begin
          w_state_nxt = RD_OUT;
        end
        RD_OUT: begin
          m_valid = 1'b1;
          if (m_ready) begin
            w_beat      = 1'b1;
            w_state_nxt = w_k_last ? LOAD : RD_REQ;
          end
        end
        default: begin
          w_state_nxt = LOAD;
        end
      endcase
    end
    if (clr) begin
      w_state_nxt = LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row    <= '0;
      r_word   <= '0;
      r_k      <= '0;
      r_x1     <= '0;
      r_x2     <= '0;
      r_x3     <= '0;
      r_m_data <= '0;
      r_m_last <= 1'b0;
      r_alert  <= 1'b0;
    end else if (clr) begin
      r_row   <= '0;
      r_word  <= '0;
      r_k     <= '0;
      r_alert <= 1'b0;
    end else if (en) begin
      if (w_accept) begin
        if (w_in_bias) begin
          r_row  <= '0;
          r_word <= '0;
        end else begin
          case (r_word)
            2'd0:    r_x1 <= s_data;
            2'd1:    r_x2 <= s_data;
            2'd2:    r_x3 <= s_data;
            default: ;
          endcase
          if (r_word == c_W_LAST) begin
            r_word <= '0;
            r_row  <= r_row + ADDR_W'(1);
          end else begin
            r_word <= r_word + 2'd1;
          end
        end
      end
      // The last result word doubles as the anomaly flag for this frame.
      if (r_state == RD_CAP) begin
        r_m_data <= xout_doutb;
        r_m_last <= w_k_last;
        if (w_k_last) begin
          r_alert <= |xout_doutb;
        end
      end
      if (w_beat) begin
        r_k <= w_k_last ? '0 : r_k + c_K_W'(1);
      end
    end
  end

  assign xij_ena    = w_row_wr;
  assign xij_wea    = {WE_W{w_row_wr}};
  assign xij_addra  = r_row;
  assign xij_dina   = w_xij_row;
  assign wb_ena     = w_row_wr | w_bias_wr;
  assign wb_wea     = {WE_W{w_row_wr | w_bias_wr}};
  assign wb_addra   = r_row;
  assign wb_dina    = w_wb_row;
  assign xout_addrb = ADDR_W'(r_k);
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;
  assign alert      = r_alert;
  assign busy       = !((r_state == LOAD) && (r_row == '0) && (r_word == '0));

endmodule
`default_nettype wire

// File: tb/tb_nn_classification_loader.sv
`default_nettype none
// tb_nn_classification_loader : directed frames checked against a frame-level
// model of the loader (accepted-word stream, BRAM rows, result beats).
module tb_nn_classification_loader;

  logic        clk = 1'b0;
  logic        rst_n, en, clr, s_valid, s_ready;
  logic [15:0] s_data;
  logic        xij_ena, wb_ena, nn_ready, nn_start, nn_done, xout_enb;
  logic [7:0]  xij_wea, wb_wea;
  logic [3:0]  xij_addra, wb_addra, xout_addrb;
  logic [63:0] xij_dina, wb_dina;
  logic [15:0] xout_doutb = '0;
  logic        m_valid, m_ready, m_last, alert, busy;
  logic [15:0] m_data;

  nn_classification_loader #(.DATA_W(16), .N_ROWS(9), .N_OUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .xij_ena(xij_ena), .xij_wea(xij_wea), .xij_addra(xij_addra), .xij_dina(xij_dina),
    .wb_ena(wb_ena), .wb_wea(wb_wea), .wb_addra(wb_addra), .wb_dina(wb_dina),
    .nn_ready(nn_ready), .nn_start(nn_start), .nn_done(nn_done),
    .xout_enb(xout_enb), .xout_addrb(xout_addrb), .xout_doutb(xout_doutb),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .alert(alert), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Environment: BRAMs attached to the DUT ports
  logic [63:0] xij_mem   [0:15] = '{default: '0};
  logic [63:0] wb_mem    [0:15] = '{default: '0};
  int          wb_wr_cnt [0:15] = '{default: 0};
  logic [15:0] xout_mem  [0:3];

  always @(posedge clk) begin
    if (xij_ena && xij_wea == 8'hFF) xij_mem[xij_addra] <= xij_dina;
    if (wb_ena && wb_wea == 8'hFF) begin
      wb_mem[wb_addra]    <= wb_dina;
      wb_wr_cnt[wb_addra] <= wb_wr_cnt[wb_addra] + 1;
    end
    if (xout_enb) xout_doutb <= xout_mem[xout_addrb[1:0]];
  end

  // Frame-level model: phase 0 loading, 1 awaiting start, 2 awaiting done, 3 reading
  int          mdl_phase = 0;
  int          mdl_n = 0;
  int          mdl_k = 0;
  logic [15:0] mdl_words [0:36];
  int          cyc = 0;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_beat = '0;
  logic [15:0] rx_data [$];
  logic        rx_last [$];
  int          rx_cyc  [$];

  always @(negedge clk) begin
    logic exp_sready, acc, exp_row, exp_wb, exp_start;
    int   ph;
    cyc++;
    if (!rst_n) begin
      check("reset_strobes", {s_ready, xij_ena, wb_ena, nn_start, xout_enb, m_valid}, 6'b0);
      mdl_phase = 0; mdl_n = 0; mdl_k = 0; prev_stall = 1'b0;
    end else begin
      ph         = mdl_phase;
      exp_sready = en && !clr && ph == 0;
      acc        = exp_sready && s_valid;
      exp_row    = acc && mdl_n < 36 && (mdl_n % 4 == 3);
      exp_wb     = acc && ((mdl_n % 4 == 3) || mdl_n == 36);
      exp_start  = en && !clr && ph == 1 && nn_ready;
      check("s_ready", s_ready, exp_sready);
      check("xij_strobe", {xij_ena, xij_wea}, {exp_row, {8{exp_row}}});
      check("wb_strobe", {wb_ena, wb_wea}, {exp_wb, {8{exp_wb}}});
      check("nn_start", nn_start, exp_start);
      check("busy", busy, !(ph == 0 && mdl_n == 0));
      if (exp_row) begin
        check("xij_addr", xij_addra, mdl_n / 4);
        check("xij_row", xij_dina, {mdl_words[mdl_n-3], mdl_words[mdl_n-2], mdl_words[mdl_n-1], 16'h0});
      end
      if (exp_wb) begin
        check("wb_addr", wb_addra, mdl_n / 4);
        check("wb_row", wb_dina, {s_data, 48'h0});
      end
      if (ph != 3) check("m_valid_idle", m_valid, 1'b0);
      if (m_valid) check("rd_during_valid", xout_enb, 1'b0);
      if (prev_stall && en && !clr) check("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_beat});
      prev_stall = m_valid && !m_ready;
      prev_beat  = {m_last, m_data};
      if (ph == 3 && m_valid && m_ready) begin
        check("beat_data", m_data, xout_mem[mdl_k]);
        check("beat_last", m_last, mdl_k == 3);
        if (mdl_k == 3) check("alert_at_last", alert, xout_mem[3] != 16'h0);
        rx_data.push_back(m_data);
        rx_last.push_back(m_last);
        rx_cyc.push_back(cyc);
        mdl_k++;
        if (mdl_k == 4) begin mdl_phase = 0; mdl_n = 0; mdl_k = 0; end
      end
      if (acc) begin
        mdl_words[mdl_n] = s_data;
        mdl_n++;
        if (mdl_n == 37) begin mdl_phase = 1; mdl_n = 0; end
      end
      if (exp_start) mdl_phase = 2;
      else if (ph == 2 && nn_done && en && !clr) begin mdl_phase = 3; mdl_k = 0; end
      if (clr) begin mdl_phase = 0; mdl_n = 0; mdl_k = 0; prev_stall = 1'b0; end
    end
  end

  task automatic send_word(input logic [15:0] w);
    int t = 0;
    s_data  = w;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && t < 100) begin @(negedge clk); t++; end
    if (!s_ready) check("send_timeout", s_ready, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((mdl_phase != 0 || busy) && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("idle_timeout", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic wait_mvalid();
    int t = 0;
    @(negedge clk);
    while (!m_valid && t < 50) begin @(negedge clk); t++; end
    if (!m_valid) check("m_valid_timeout", m_valid, 1'b1);
  endtask

  task automatic pulse_done();
    nn_done = 1'b1;
    @(posedge clk); #1;
    nn_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int base, lat;
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; s_valid = 1'b1; s_data = 16'hFFFF;
    nn_ready = 1'b1; nn_done = 1'b1; m_ready = 1'b1;
    xout_mem[0] = 16'h0100; xout_mem[1] = 16'h0200;
    xout_mem[2] = 16'h0300; xout_mem[3] = 16'h0001;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; s_valid = 1'b0; nn_ready = 1'b0; nn_done = 1'b0;
    @(negedge clk);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 16'h0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_alert", alert, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_s_ready", s_ready, 1'b1);
    @(posedge clk); #1;

    // Frame 1: row 0 = 0,0,0,034C, bias F3A3, nn_ready late by 5 cycles
    for (int i = 0; i < 37; i++) begin
      if (i < 3)       send_word(16'h0000);
      else if (i == 3) send_word(16'h034C);
      else if (i == 36) send_word(16'hF3A3);
      else             send_word(16'h1000 + 16'(i));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); check("start_held", nn_start, 1'b0);
      @(posedge clk); #1;
    end
    nn_ready = 1'b1;
    @(negedge clk); check("start_pulse", nn_start, 1'b1);
    @(posedge clk); #1;
    @(negedge clk); check("start_once", nn_start, 1'b0);
    check("xij_row0", xij_mem[0], 64'h0);
    check("wb_row0", wb_mem[0], 64'h034C_0000_0000_0000);
    check("wb_row0_writes", wb_wr_cnt[0], 1);
    check("xij_row1", xij_mem[1], 64'h1004_1005_1006_0000);
    check("xij_row8", xij_mem[8], 64'h1020_1021_1022_0000);
    check("wb_row8", wb_mem[8], 64'h1023_0000_0000_0000);
    check("wb_bias", wb_mem[9], 64'hF3A3_0000_0000_0000);
    check("wb_bias_writes", wb_wr_cnt[9], 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    base = rx_data.size();
    pulse_done();
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (m_valid) break;
      @(posedge clk); #1;
      lat++;
    end
    check("first_valid_latency", lat, 3);
    @(posedge clk); #1;
    wait_idle();
    check("f1_beats", rx_data.size() - base, 4);
    if (rx_data.size() >= base + 4) begin
      check("f1_data", {rx_data[base], rx_data[base+1], rx_data[base+2], rx_data[base+3]},
            64'h0100_0200_0300_0001);
      check("f1_last", {rx_last[base], rx_last[base+1], rx_last[base+2], rx_last[base+3]}, 4'b0001);
      check("beat_spacing", rx_cyc[base+1] - rx_cyc[base], 3);
    end
    check("f1_alert", alert, 1'b1);

    // Frame 2: stall beat 1 for 4 cycles, last result zero clears alert
    xout_mem[3] = 16'h0000;
    for (int i = 0; i < 37; i++) send_word(16'h2000 + 16'(i));
    repeat (3) begin @(posedge clk); #1; end
    base = rx_data.size();
    pulse_done();
    wait_mvalid();
    @(posedge clk); #1;
    m_ready = 1'b0;
    wait_mvalid();
    for (int i = 0; i < 4; i++) begin
      check("stall_data", m_data, 16'h0200);
      check("stall_valid", m_valid, 1'b1);
      check("stall_no_read", xout_enb, 1'b0);
      check("stall_alert_held", alert, 1'b1);
      @(posedge clk); #1;
      if (i == 3) m_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    wait_idle();
    check("f2_beats", rx_data.size() - base, 4);
    check("f2_alert", alert, 1'b0);

    // Frame 3: en dropped after 10 words, resumes at row 2 word 2
    xout_mem[3] = 16'h8000;
    for (int i = 0; i < 10; i++) send_word(16'h3000 + 16'(i));
    s_data = 16'h300A; s_valid = 1'b1; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("pause_s_ready", s_ready, 1'b0);
      check("pause_writes", {xij_ena, wb_ena}, 2'b00);
      check("pause_busy", busy, 1'b1);
      @(posedge clk); #1;
    end
    en = 1'b1;
    for (int i = 10; i < 37; i++) send_word(16'h3000 + 16'(i));
    check("f3_xij_row2", xij_mem[2], 64'h3008_3009_300A_0000);
    check("f3_wb_row2", wb_mem[2], 64'h300B_0000_0000_0000);
    check("f3_wb_bias", wb_mem[9], 64'h3024_0000_0000_0000);
    repeat (3) begin @(posedge clk); #1; end
    pulse_done();
    wait_idle();
    check("f3_alert", alert, 1'b1);

    // Frame 4: clr while waiting for done, then a late nn_done is ignored
    for (int i = 0; i < 37; i++) send_word(16'h4000 + 16'(i));
    repeat (3) begin @(posedge clk); #1; end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    pulse_done();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("clr_m_valid", m_valid, 1'b0);
      check("clr_busy", busy, 1'b0);
      check("clr_alert", alert, 1'b0);
      @(posedge clk); #1;
    end

    // Partial frame discarded by clr, next frame starts again at row 0
    for (int i = 0; i < 5; i++) send_word(16'h4F00 + 16'(i));
    @(negedge clk); check("partial_busy", busy, 1'b1);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk); check("partial_cleared", busy, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 37; i++) send_word(16'h5000 + 16'(i));
    check("f5_xij_row0", xij_mem[0], 64'h5000_5001_5002_0000);
    check("f5_wb_row0", wb_mem[0], 64'h5003_0000_0000_0000);
    repeat (3) begin @(posedge clk); #1; end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nn_classification_loader.md
NN_CLASSIFICATION_LOADER -- requirements
Module: nn_classification_loader

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, Q6.10 word width; N_ROWS, default 9, input rows; N_OUT, default 4, result words.
REQ-002 SHALL have ports: clk  in  1  system clock.
REQ-003 SHALL have ports: rst_n  in  1  synchronous active-low reset.
REQ-004 SHALL have ports: en  in  1  global advance enable; clr  in  1  synchronous clear.
REQ-005 SHALL have ports: s_valid  in  1, s_ready  out  1, s_data  in  16  input word stream.
REQ-006 SHALL have ports: xij_ena  out  1, xij_wea  out  8, xij_addra  out  4, xij_dina  out  64  x BRAM port A.
REQ-007 SHALL have ports: wb_ena  out  1, wb_wea  out  8, wb_addra  out  4, wb_dina  out  64  weight/bias BRAM port A.
REQ-008 SHALL have ports: nn_ready  in  1, nn_start  out  1, nn_done  in  1  classifier handshake.
REQ-009 SHALL have ports: xout_enb  out  1, xout_addrb  out  4, xout_doutb  in  16  result BRAM port B.
REQ-010 SHALL have ports: m_valid  out  1, m_ready  in  1, m_data  out  16, m_last  out  1, alert  out  1, busy  out  1.

Function
REQ-011 SHALL implement states LOAD, START, WAIT_DONE, RD_REQ, RD_CAP, RD_OUT; no state, counter or register changes while en=0, and all strobes are 0 then.
REQ-012 SHALL accept 37 words per frame in LOAD: rows 0..8 as x1, x2, x3, w, then one bias word; s_ready = (state==LOAD) & en.
REQ-013 SHALL register x1..x3; in the cycle w of row r is accepted, it drives xij_ena=1, xij_wea=8'hFF, xij_addra=r, xij_dina={x1,x2,x3,16'h0}, and wb_ena=1, wb_wea=8'hFF, wb_addra=r, wb_dina={w,48'h0}.
REQ-014 SHALL, in the bias accept cycle, drive only the wb write at addr 9 with {bias,48'h0}, then enter START; otherwise all port-A enables and wea are 0.
REQ-015 SHALL, in START, drive nn_start combinationally = nn_ready & en for exactly one cycle, then enter WAIT_DONE; with nn_ready=0 it waits indefinitely.
REQ-016 SHALL move WAIT_DONE->RD_REQ on nn_done=1; nn_done is ignored in every other state.
REQ-017 SHALL, in RD_REQ, drive xout_enb=1, xout_addrb=k (k=0..3); in RD_CAP capture xout_doutb into m_data; in RD_OUT assert m_valid with m_last=(k==3).
REQ-018 SHALL give first m_valid 3 cycles after the nn_done cycle, with 3 cycles minimum per result word.
REQ-019 SHALL hold m_data/m_last stable while m_valid=1 and m_ready=0; on handshake k increments and returns to RD_REQ, or after k=3 returns to LOAD with counters zeroed.
REQ-020 SHALL set alert <= (captured word k=3 != 0) at the k=3 capture; alert holds until the next frame's capture, clr, or reset.
REQ-021 SHALL drive busy=1 unless in LOAD with zero words accepted.
REQ-022 SHALL, on clr=1 (regardless of en), return to LOAD, zero counters, and drop m_valid/alert; a partial frame is discarded.

Reset
REQ-023 SHALL, on rst_n=0 at a clk edge, set state LOAD, row/word/k counters 0, x registers 0, m_valid 0, m_data 0, m_last 0, alert 0; all BRAM strobes and nn_start are 0 while rst_n=0.

Structure
REQ-024 SHALL take DATA_W, BRAM_W=64, ADDR_W=4, N_ROWS=9, N_WB=10, N_OUT=4 and the state enumeration from shared package nn_cls_pkg.
REQ-025 SHALL contain one sub-module, nn_cls_row_packer (x1..x3/w word to 64-bit row formatter), all else inline.

Verification
REQ-026 Row 0 words 0,0,0,16'h034C -> xij addr0 = 64'h0, wb addr0 = 64'h034C_0000_0000_0000, single-cycle wea=8'hFF.
REQ-027 Full frame ending with bias 16'hF3A3 -> wb addr9 = 64'hF3A3_0000_0000_0000, then nn_start is one cycle once nn_ready=1; nn_ready held 0 for 5 cycles -> nn_start delayed 5 cycles.
REQ-028 nn_done pulse, xout = {16'h0100,16'h0200,16'h0300,16'h0001}, m_ready=1 -> four beats in order, m_last on 4th only, alert=1, first m_valid 3 cycles after nn_done.
REQ-029 m_ready=0 for 4 cycles on beat 1 -> m_data stays 16'h0200, no xout reads issued meanwhile.
REQ-030 en=0 during LOAD after 10 words -> s_ready=0, no writes; resuming continues at row 2 word 2.
REQ-031 clr in WAIT_DONE, then nn_done=1 -> ignored, state LOAD, m_valid=0, alert=0, busy=0.
